stbus_tx_framer: RTL
====================

# stbus_tx_framer

ST-BUS master transmitter: generates the 8 kHz active-low frame pulse and serial 2.048 Mbit/s TDM data (32 timeslots × 8 bits) from the 4.096 MHz c4 clock. It is the far end of our F0/C4 converter path and produces the f0/data stream that the converter and receive logic consume. Parallel bytes enter through a valid/ready handshake and are serialised MSB-first, one per timeslot. An idle pattern is inserted on underrun.

## Interface
- IDLE, 8'hFF: byte transmitted when no data is held at a slot load.
- c4  in  1  4.096 MHz clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  8  byte for the next timeslot.
- din_valid  in  1  din is valid.
- din_ready  out  1  holding register empty; the byte is accepted on an edge where din_valid & din_ready.
- f0_n  out  1  frame pulse, active low, one c4 cycle per frame.
- dx  out  1  serial data, MSB first.
- ts  out  5  timeslot currently on dx (0..31).
- underrun  out  1  one-cycle pulse: IDLE was loaded because the holding register was empty.

## Operation
- cnt: 9-bit free-running counter, 0..511, wraps 511→0. One frame = 512 c4 cycles = 125 µs.
- ts = cnt[8:4]; bit cell = cnt[3:1]; each bit lasts 2 c4 cycles.
- f0_n = 0 exactly while cnt == 511, otherwise 1. Decode from cnt, glitch-free: use a registered compare of the next count.
- Holding register hold[7:0] with flag hold_full; din_ready = !hold_full.
- Shift register sr[7:0]; dx = sr[7].
- On the edge where cnt becomes a slot start (new cnt[3:0] == 0):
  - if hold_full: sr <= hold, hold_full <= 0;
  - else: sr <= IDLE and underrun <= 1 for that cycle.
- On the edge where new cnt[0] == 0 and new cnt[3:0] != 0: sr <= {sr[6:0], 1'b0}.
- Otherwise sr holds its value.
- Accept and load on the same edge: the load sees hold_full as it was before the edge. So if hold was empty, IDLE is loaded and the accepted byte goes into hold for the next slot. No byte is lost or duplicated.
- While hold_full = 1, din_valid is ignored (din_ready = 0).
- No per-frame state: slot 31 is followed directly by slot 0 of the next frame using the same rules.

## Timing
- Reset values (asynchronous):
  - cnt = 0, sr = IDLE, hold_full = 0, underrun = 0.
  - Hence f0_n = 1, dx = 1, ts = 0, din_ready = 1.
- din_valid is ignored while rst_n is low.
- After reset, slot 0 of the first partial frame transmits IDLE with no underrun pulse, because no load edge occurred. The first load edge is cnt 15→16.
- First f0_n low: the cycle with cnt == 511, i.e. 511 edges after reset release. Then every 512 cycles.
- Data latency: a byte accepted at any edge up to and including the edge into cnt = 16k+15 appears on dx from cnt = 16(k+1). Its MSB lasts 2 cycles and its LSB ends at cnt = 16(k+1)+15.
- Sustained throughput: one byte per 16 cycles. din_ready returns high on the load edge, so the source has 16 cycles to refill.
- underrun is high exactly for the cycle where new cnt[3:0] == 0 and IDLE was loaded.
- Reset asserted mid-slot: all state clears immediately. Any partly sent byte and the held byte are discarded, and the framing restarts from cnt = 0.

## Test plan
- Free-run with din_valid = 0 after reset:
  - f0_n low at cycles 511, 1023 and 1535 after reset, each low for exactly 1 cycle.
  - dx constantly 1.
  - underrun pulses at every cnt[3:0] == 0 except the very first slot 0.
- Write 0xA5 at cnt = 10:
  - din_ready falls the next cycle.
  - Over cnt 16..31, dx = 1,0,1,0,0,1,0,1, each bit held 2 cycles.
  - ts = 1 throughout; no underrun at cnt 16.
- Back-to-back stream: keep din_valid high with bytes 0x00..0x1F, source refilling whenever din_ready is high.
  - Once streaming, consecutive slots carry consecutive bytes with no IDLE gaps.
  - Wrap across f0_n (slot 31 → slot 0) with no underrun.
- Simultaneous accept and load: present 0x3C with din_valid rising on the edge into cnt = 32 while hold is empty.
  - Slot 2 transmits 0xFF and underrun pulses.
  - Slot 3 transmits 0x3C.
- Hold full: while holding 0x11, drive din_valid with 0x22.
  - din_ready stays 0; 0x22 is not accepted until after the load.
  - Slot shows 0x11.
- Reset mid-operation: assert rst_n low at cnt = 200 with hold full.
  - dx = 1, f0_n = 1 and din_ready = 1 immediately.
  - After release, the next f0_n low occurs 511 cycles later and the held byte is never transmitted.

Source files
------------

// File: rtl/stbus_tx_framer.sv
// ST-BUS master transmitter: 8 kHz frame pulse plus 32x8-bit TDM serial data from c4.
// Bytes arrive through a one-deep valid/ready holding register; IDLE fills empty slots.
module stbus_tx_framer (
  input  logic       c4,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       f0_n,
  output logic       dx,
  output logic [4:0] ts,
  output logic       underrun
);

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] IDLE     = 8'hFF;
  localparam logic [CNT_W-1:0]  CNT_LAST = '1;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [BYTE_W-1:0] sr;
  logic [BYTE_W-1:0] hold;
  logic              slot_start;
  logic              shift_en;
  logic              accept;

  // Edge qualifiers are decoded from the count the register is about to take.
  always_comb begin
    cnt_nxt    = cnt + CNT_W'(1);
    slot_start = (cnt_nxt[3:0] == 4'd0);
    shift_en   = !cnt_nxt[0] && !slot_start;
    accept     = din_valid && din_ready;
  end

  // Free-running frame counter; f0_n is a registered compare so it cannot glitch.
  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      f0_n <= 1'b1;
    end else begin
      cnt  <= cnt_nxt;
      f0_n <= (cnt_nxt != CNT_LAST);
    end
  end

  // Shift register: load at slot start, shift every second cycle inside the slot.
  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= IDLE;
      underrun <= 1'b0;
    end else begin
      underrun <= slot_start && din_ready;
      if (slot_start) begin
        sr <= din_ready ? IDLE : hold;
      end else if (shift_en) begin
        sr <= {sr[BYTE_W-2:0], 1'b0};
      end
    end
  end

  // Holding register; din_ready is the registered "hold empty" flag. A load and an
  // accept cannot collide because accept needs the register empty before the edge.
  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      din_ready <= 1'b1;
    end else begin
      if (accept) begin
        hold      <= din;
        din_ready <= 1'b0;
      end else if (slot_start && !din_ready) begin
        din_ready <= 1'b1;
      end
    end
  end

  assign dx = sr[BYTE_W-1];
  assign ts = cnt[CNT_W-1:4];

endmodule
